// File: rtl/axi4lite_arb_pkg.sv
// Shared types and constants for the two-requester AXI4-Lite arbiter.
package axi4lite_arb_pkg;

  // One transaction in flight at a time; write and read phases are sequenced.
  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StWrResp,
    StRd,
    StRdData
  } state_e;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespExOkay = 2'b01;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin owner selection; purely combinational.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic [1:0] grant
);

  // On a tie the requester that did not own the slave last time wins.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_owner ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/axi4lite_arb_2m1s.sv
// AXI4-Lite arbiter: two requesters share one slave, one transaction at a time.
module axi4lite_arb_2m1s
  import axi4lite_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // Requester 0
  input  logic [ADDR_WIDTH-1:0] m0_axi_awaddr,
  input  logic                  m0_axi_awvalid,
  output logic                  m0_axi_awready,
  input  logic [DATA_WIDTH-1:0] m0_axi_wdata,
  input  logic                  m0_axi_wvalid,
  output logic                  m0_axi_wready,
  output logic [1:0]            m0_axi_bresp,
  output logic                  m0_axi_bvalid,
  input  logic                  m0_axi_bready,
  input  logic [ADDR_WIDTH-1:0] m0_axi_araddr,
  input  logic                  m0_axi_arvalid,
  output logic                  m0_axi_arready,
  output logic [DATA_WIDTH-1:0] m0_axi_rdata,
  output logic [1:0]            m0_axi_rresp,
  output logic                  m0_axi_rvalid,
  input  logic                  m0_axi_rready,
  // Requester 1
  input  logic [ADDR_WIDTH-1:0] m1_axi_awaddr,
  input  logic                  m1_axi_awvalid,
  output logic                  m1_axi_awready,
  input  logic [DATA_WIDTH-1:0] m1_axi_wdata,
  input  logic                  m1_axi_wvalid,
  output logic                  m1_axi_wready,
  output logic [1:0]            m1_axi_bresp,
  output logic                  m1_axi_bvalid,
  input  logic                  m1_axi_bready,
  input  logic [ADDR_WIDTH-1:0] m1_axi_araddr,
  input  logic                  m1_axi_arvalid,
  output logic                  m1_axi_arready,
  output logic [DATA_WIDTH-1:0] m1_axi_rdata,
  output logic [1:0]            m1_axi_rresp,
  output logic                  m1_axi_rvalid,
  input  logic                  m1_axi_rready,
  // Shared slave
  output logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  output logic                  s_axi_awvalid,
  input  logic                  s_axi_awready,
  output logic [DATA_WIDTH-1:0] s_axi_wdata,
  output logic                  s_axi_wvalid,
  input  logic                  s_axi_wready,
  input  logic [1:0]            s_axi_bresp,
  input  logic                  s_axi_bvalid,
  output logic                  s_axi_bready,
  output logic [ADDR_WIDTH-1:0] s_axi_araddr,
  output logic                  s_axi_arvalid,
  input  logic                  s_axi_arready,
  input  logic [DATA_WIDTH-1:0] s_axi_rdata,
  input  logic [1:0]            s_axi_rresp,
  input  logic                  s_axi_rvalid,
  output logic                  s_axi_rready,
  output logic [1:0]            gnt,
  output logic                  busy
);

  state_e     state_q, state_d;
  logic [1:0] gnt_q, gnt_d;
  logic       last_owner_q, last_owner_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;

  logic [1:0] req;
  logic [1:0] arb_grant;
  logic       owner;
  logic       aw_hs, w_hs;

  // Owner-side views of the requester inputs.
  logic [ADDR_WIDTH-1:0] own_awaddr, own_araddr;
  logic [DATA_WIDTH-1:0] own_wdata;
  logic                  own_awvalid, own_wvalid, own_bready, own_arvalid, own_rready;

  // Response signals headed for the owner before gating by gnt.
  logic                  o_awready, o_wready, o_bvalid, o_arready, o_rvalid;
  logic [1:0]            o_bresp, o_rresp;
  logic [DATA_WIDTH-1:0] o_rdata;

  assign req   = {m1_axi_awvalid | m1_axi_arvalid, m0_axi_awvalid | m0_axi_arvalid};
  assign owner = gnt_q[1];

  rr_arb2 u_rr_arb2 (
    .req        (req),
    .last_owner (last_owner_q),
    .grant      (arb_grant)
  );

  assign own_awaddr  = owner ? m1_axi_awaddr  : m0_axi_awaddr;
  assign own_awvalid = owner ? m1_axi_awvalid : m0_axi_awvalid;
  assign own_wdata   = owner ? m1_axi_wdata   : m0_axi_wdata;
  assign own_wvalid  = owner ? m1_axi_wvalid  : m0_axi_wvalid;
  assign own_bready  = owner ? m1_axi_bready  : m0_axi_bready;
  assign own_araddr  = owner ? m1_axi_araddr  : m0_axi_araddr;
  assign own_arvalid = owner ? m1_axi_arvalid : m0_axi_arvalid;
  assign own_rready  = owner ? m1_axi_rready  : m0_axi_rready;

  // Route the active channel between owner and slave; everything else held at zero.
  always_comb begin
    s_axi_awaddr  = '0;
    s_axi_awvalid = 1'b0;
    s_axi_wdata   = '0;
    s_axi_wvalid  = 1'b0;
    s_axi_bready  = 1'b0;
    s_axi_araddr  = '0;
    s_axi_arvalid = 1'b0;
    s_axi_rready  = 1'b0;
    o_awready     = 1'b0;
    o_wready      = 1'b0;
    o_bvalid      = 1'b0;
    o_bresp       = 2'b00;
    o_arready     = 1'b0;
    o_rvalid      = 1'b0;
    o_rdata       = '0;
    o_rresp       = 2'b00;
    case (state_q)
      StWr: begin
        // A channel that already handshook stays quiet until the response phase.
        s_axi_awaddr  = own_awaddr;
        s_axi_awvalid = own_awvalid & ~aw_done_q;
        s_axi_wdata   = own_wdata;
        s_axi_wvalid  = own_wvalid & ~w_done_q;
        o_awready     = s_axi_awready & ~aw_done_q;
        o_wready      = s_axi_wready & ~w_done_q;
      end
      StWrResp: begin
        s_axi_bready = own_bready;
        o_bvalid     = s_axi_bvalid;
        o_bresp      = s_axi_bresp;
      end
      StRd: begin
        s_axi_araddr  = own_araddr;
        s_axi_arvalid = own_arvalid;
        o_arready     = s_axi_arready;
      end
      StRdData: begin
        s_axi_rready = own_rready;
        o_rvalid     = s_axi_rvalid;
        o_rdata      = s_axi_rdata;
        o_rresp      = s_axi_rresp;
      end
      default: ;
    endcase
  end

  assign m0_axi_awready = gnt_q[0] & o_awready;
  assign m0_axi_wready  = gnt_q[0] & o_wready;
  assign m0_axi_bvalid  = gnt_q[0] & o_bvalid;
  assign m0_axi_bresp   = gnt_q[0] ? o_bresp : 2'b00;
  assign m0_axi_arready = gnt_q[0] & o_arready;
  assign m0_axi_rvalid  = gnt_q[0] & o_rvalid;
  assign m0_axi_rdata   = gnt_q[0] ? o_rdata : '0;
  assign m0_axi_rresp   = gnt_q[0] ? o_rresp : 2'b00;

  assign m1_axi_awready = gnt_q[1] & o_awready;
  assign m1_axi_wready  = gnt_q[1] & o_wready;
  assign m1_axi_bvalid  = gnt_q[1] & o_bvalid;
  assign m1_axi_bresp   = gnt_q[1] ? o_bresp : 2'b00;
  assign m1_axi_arready = gnt_q[1] & o_arready;
  assign m1_axi_rvalid  = gnt_q[1] & o_rvalid;
  assign m1_axi_rdata   = gnt_q[1] ? o_rdata : '0;
  assign m1_axi_rresp   = gnt_q[1] ? o_rresp : 2'b00;

  assign aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_hs  = s_axi_wvalid & s_axi_wready;

  // Transaction sequencing, ownership and handshake bookkeeping.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_owner_d = last_owner_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    case (state_q)
      StIdle: begin
        if (|req) begin
          gnt_d     = arb_grant;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          // Pending write takes precedence over a read from the same requester.
          state_d   = (arb_grant[1] ? m1_axi_awvalid : m0_axi_awvalid) ? StWr : StRd;
        end
      end
      StWr: begin
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          state_d   = StWrResp;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          aw_done_d = aw_done_q | aw_hs;
          w_done_d  = w_done_q | w_hs;
        end
      end
      StWrResp: begin
        if (s_axi_bvalid && s_axi_bready) begin
          state_d      = StIdle;
          last_owner_d = owner;
          gnt_d        = 2'b00;
        end
      end
      StRd: begin
        if (s_axi_arvalid && s_axi_arready) state_d = StRdData;
      end
      StRdData: begin
        if (s_axi_rvalid && s_axi_rready) begin
          state_d      = StIdle;
          last_owner_d = owner;
          gnt_d        = 2'b00;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register; reset abandons any in-flight transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      gnt_q        <= 2'b00;
      last_owner_q <= 1'b1;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_owner_q <= last_owner_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
    end
  end

  assign gnt  = gnt_q;
  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_axi4lite_arb_2m1s.sv
// Directed bench for the two-requester AXI4-Lite arbiter.
module tb_axi4lite_arb_2m1s;

  logic        clk, rst;
  logic [3:0]  m0_awaddr, m0_araddr, m1_awaddr, m1_araddr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_awvalid, m0_wvalid, m0_bready, m0_arvalid, m0_rready;
  logic        m1_awvalid, m1_wvalid, m1_bready, m1_arvalid, m1_rready;
  logic        m0_awready, m0_wready, m0_bvalid, m0_arready, m0_rvalid;
  logic        m1_awready, m1_wready, m1_bvalid, m1_arready, m1_rvalid;
  logic [1:0]  m0_bresp, m0_rresp, m1_bresp, m1_rresp;
  logic [31:0] m0_rdata, m1_rdata;
  logic [3:0]  s_awaddr, s_araddr;
  logic [31:0] s_wdata, s_rdata;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic [1:0]  s_bresp, s_rresp;
  logic [1:0]  gnt;
  logic        busy;

  int checks = 0;
  int errors = 0;

  axi4lite_arb_2m1s dut (
    .clk(clk), .rst(rst),
    .m0_axi_awaddr(m0_awaddr), .m0_axi_awvalid(m0_awvalid), .m0_axi_awready(m0_awready),
    .m0_axi_wdata(m0_wdata), .m0_axi_wvalid(m0_wvalid), .m0_axi_wready(m0_wready),
    .m0_axi_bresp(m0_bresp), .m0_axi_bvalid(m0_bvalid), .m0_axi_bready(m0_bready),
    .m0_axi_araddr(m0_araddr), .m0_axi_arvalid(m0_arvalid), .m0_axi_arready(m0_arready),
    .m0_axi_rdata(m0_rdata), .m0_axi_rresp(m0_rresp), .m0_axi_rvalid(m0_rvalid),
    .m0_axi_rready(m0_rready),
    .m1_axi_awaddr(m1_awaddr), .m1_axi_awvalid(m1_awvalid), .m1_axi_awready(m1_awready),
    .m1_axi_wdata(m1_wdata), .m1_axi_wvalid(m1_wvalid), .m1_axi_wready(m1_wready),
    .m1_axi_bresp(m1_bresp), .m1_axi_bvalid(m1_bvalid), .m1_axi_bready(m1_bready),
    .m1_axi_araddr(m1_araddr), .m1_axi_arvalid(m1_arvalid), .m1_axi_arready(m1_arready),
    .m1_axi_rdata(m1_rdata), .m1_axi_rresp(m1_rresp), .m1_axi_rvalid(m1_rvalid),
    .m1_axi_rready(m1_rready),
    .s_axi_awaddr(s_awaddr), .s_axi_awvalid(s_awvalid), .s_axi_awready(s_awready),
    .s_axi_wdata(s_wdata), .s_axi_wvalid(s_wvalid), .s_axi_wready(s_wready),
    .s_axi_bresp(s_bresp), .s_axi_bvalid(s_bvalid), .s_axi_bready(s_bready),
    .s_axi_araddr(s_araddr), .s_axi_arvalid(s_arvalid), .s_axi_arready(s_arready),
    .s_axi_rdata(s_rdata), .s_axi_rresp(s_rresp), .s_axi_rvalid(s_rvalid),
    .s_axi_rready(s_rready),
    .gnt(gnt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    m0_awaddr = '0; m0_araddr = '0; m0_wdata = '0;
    m0_awvalid = 0; m0_wvalid = 0; m0_bready = 0; m0_arvalid = 0; m0_rready = 0;
    m1_awaddr = '0; m1_araddr = '0; m1_wdata = '0;
    m1_awvalid = 0; m1_wvalid = 0; m1_bready = 0; m1_arvalid = 0; m1_rready = 0;
    s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = '0;
    s_arready = 0; s_rvalid = 0; s_rdata = '0; s_rresp = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++;
    if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b want 00", gnt); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if ({s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready} !== 5'b0) begin
      errors++;
      $display("FAIL reset_slave_ctl: got %b want 00000",
               {s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready});
    end
  endtask

  task automatic test_single_write();
    @(negedge clk);
    m0_awaddr = 4'h4; m0_awvalid = 1; m0_wdata = 32'hDEADBEEF; m0_wvalid = 1; m0_bready = 1;
    s_awready = 1; s_wready = 1;
    #1;
    checks++;
    if ({s_awvalid, s_wvalid, gnt} !== 4'b0) begin
      errors++; $display("FAIL wr_arb_cycle: got %b want 0000", {s_awvalid, s_wvalid, gnt});
    end
    @(negedge clk); #1;
    checks++;
    if (gnt !== 2'b01) begin errors++; $display("FAIL wr_gnt: got %b want 01", gnt); end
    checks++;
    if (s_awaddr !== 4'h4) begin errors++; $display("FAIL wr_awaddr: got %h want 4", s_awaddr); end
    checks++;
    if (s_wdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr_wdata: got %h want deadbeef", s_wdata);
    end
    checks++;
    if ({s_awvalid, s_wvalid, m0_awready, m1_awready} !== 4'b1110) begin
      errors++;
      $display("FAIL wr_valids: got %b want 1110", {s_awvalid, s_wvalid, m0_awready, m1_awready});
    end
    @(negedge clk);
    m0_awvalid = 0; m0_wvalid = 0;
    s_bvalid = 1; s_bresp = 2'b00;
    #1;
    checks++;
    if ({m0_bvalid, m0_bresp, m1_bvalid, s_bready, s_awvalid} !== 6'b100010) begin
      errors++;
      $display("FAIL wr_bresp: got %b want 100010",
               {m0_bvalid, m0_bresp, m1_bvalid, s_bready, s_awvalid});
    end
    @(negedge clk);
    s_bvalid = 0; m0_bready = 0;
    #1;
    checks++;
    if ({busy, gnt} !== 3'b000) begin
      errors++; $display("FAIL wr_idle: got busy/gnt %b want 000", {busy, gnt});
    end
  endtask

  task automatic test_contend_read();
    apply_reset();
    m0_araddr = 4'h1; m0_arvalid = 1; m0_rready = 1;
    m1_araddr = 4'h2; m1_arvalid = 1; m1_rready = 1;
    s_arready = 1;
    @(negedge clk); #1;
    checks++;
    if ({gnt, s_araddr, m0_arready, m1_arready} !== 8'b01_0001_10) begin
      errors++;
      $display("FAIL rd_first_owner: got gnt %b addr %h rdy %b%b want 01 1 10",
               gnt, s_araddr, m0_arready, m1_arready);
    end
    @(negedge clk);
    m0_arvalid = 0;
    s_rvalid = 1; s_rdata = 32'hAAAA5555; s_rresp = 2'b00;
    #1;
    checks++;
    if (m0_rdata !== 32'hAAAA5555 || m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rd_m0_data: got %h v%b m1v%b want aaaa5555 v1 m1v0",
               m0_rdata, m0_rvalid, m1_rvalid);
    end
    @(negedge clk);
    s_rvalid = 0;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rd_gap_idle: got busy %b want 0", busy); end
    @(negedge clk); #1;
    checks++;
    if (gnt !== 2'b10 || s_araddr !== 4'h2) begin
      errors++; $display("FAIL rd_second_owner: got gnt %b addr %h want 10 2", gnt, s_araddr);
    end
    @(negedge clk);
    m1_arvalid = 0;
    s_rvalid = 1; s_rdata = 32'h12345678;
    #1;
    checks++;
    if (m1_rdata !== 32'h12345678 || m1_rvalid !== 1'b1) begin
      errors++; $display("FAIL rd_m1_data: got %h v%b want 12345678 v1", m1_rdata, m1_rvalid);
    end
    checks++;
    if (m0_rdata !== 32'h0 || m0_rvalid !== 1'b0) begin
      errors++; $display("FAIL rd_m0_isolated: got %h v%b want 0 v0", m0_rdata, m0_rvalid);
    end
    @(negedge clk);
    s_rvalid = 0; m0_rready = 0; m1_rready = 0; s_arready = 0;
  endtask

  task automatic test_back_to_back();
    logic [1:0] seq [6];
    logic [1:0] prev;
    int         n;
    for (int i = 0; i < 6; i++) seq[i] = 2'b00;
    prev = 2'b00;
    n = 0;
    @(negedge clk);
    m0_awaddr = 4'hA; m0_awvalid = 1; m0_wdata = 32'h0000000A; m0_wvalid = 1; m0_bready = 1;
    m1_awaddr = 4'hB; m1_awvalid = 1; m1_wdata = 32'h0000000B; m1_wvalid = 1; m1_bready = 1;
    s_awready = 1; s_wready = 1; s_bvalid = 1; s_bresp = 2'b00;
    for (int c = 0; c < 60 && n < 6; c++) begin
      @(negedge clk); #1;
      if (gnt != 2'b00 && prev == 2'b00) begin
        seq[n] = gnt;
        n++;
      end
      prev = gnt;
    end
    checks++;
    if (n != 6) begin errors++; $display("FAIL b2b_timeout: got %0d grants want 6", n); end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (seq[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        errors++;
        $display("FAIL b2b_gnt%0d: got %b want %b", i, seq[i], (i % 2 == 0) ? 2'b01 : 2'b10);
      end
    end
    @(negedge clk);
    @(negedge clk);
    idle_inputs();
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got busy %b want 0", busy); end
  endtask

  task automatic test_w_before_aw();
    int aw_cnt = 0;
    int w_cnt = 0;
    @(negedge clk);
    m0_awaddr = 4'h8; m0_awvalid = 1; m0_wdata = 32'h0BADF00D; m0_wvalid = 1; m0_bready = 1;
    s_awready = 0; s_wready = 1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 2) m0_wvalid = 0;
      if (c == 4) s_awready = 1;
      if (c == 5) begin
        m0_awvalid = 0; s_bvalid = 1; s_bresp = 2'b11;
      end
      #1;
      if (s_awvalid && s_awready) aw_cnt++;
      if (s_wvalid && s_wready) w_cnt++;
      if (c == 4) begin
        checks++;
        if ({busy, s_bready} !== 2'b10) begin
          errors++; $display("FAIL wfirst_still_wr: got busy/bready %b want 10", {busy, s_bready});
        end
      end
    end
    checks++;
    if (s_bready !== 1'b1 || m0_bvalid !== 1'b1 || m0_bresp !== 2'b11) begin
      errors++;
      $display("FAIL wfirst_wr_resp: got bready %b bvalid %b bresp %b want 1 1 11",
               s_bready, m0_bvalid, m0_bresp);
    end
    checks++;
    if (aw_cnt != 1 || w_cnt != 1) begin
      errors++; $display("FAIL wfirst_hs_count: got aw %0d w %0d want 1 1", aw_cnt, w_cnt);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL wfirst_idle: got busy %b want 0", busy); end
  endtask

  task automatic test_rresp_err();
    @(negedge clk);
    m1_araddr = 4'h6; m1_arvalid = 1; m1_rready = 1;
    s_arready = 1;
    @(negedge clk); #1;
    checks++;
    if (gnt !== 2'b10) begin errors++; $display("FAIL err_gnt: got %b want 10", gnt); end
    @(negedge clk);
    m1_arvalid = 0;
    s_rvalid = 1; s_rdata = 32'hCAFE0001; s_rresp = 2'b10;
    #1;
    checks++;
    if (m1_rresp !== 2'b10 || m1_rvalid !== 1'b1 || m0_rresp !== 2'b00) begin
      errors++;
      $display("FAIL err_rresp: got m1 %b v%b m0 %b want 10 v1 00", m1_rresp, m1_rvalid, m0_rresp);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if ({busy, gnt} !== 3'b000) begin
      errors++; $display("FAIL err_idle: got busy/gnt %b want 000", {busy, gnt});
    end
  endtask

  task automatic test_reset_mid();
    // M0 completes a read first so that without reset M1 would win the next tie.
    @(negedge clk);
    m0_araddr = 4'h3; m0_arvalid = 1; m0_rready = 1;
    s_arready = 1;
    @(negedge clk);
    @(negedge clk);
    m0_arvalid = 0; s_rvalid = 1; s_rdata = 32'h00000033;
    @(negedge clk);
    s_rvalid = 0;
    m1_araddr = 4'h5; m1_arvalid = 1; m1_rready = 1;
    @(negedge clk);
    @(negedge clk);
    m1_arvalid = 0;
    #1;
    checks++;
    if ({busy, gnt, s_rready} !== 4'b1101) begin
      errors++; $display("FAIL mid_in_rd_data: got busy/gnt/rready %b want 1101",
                         {busy, gnt, s_rready});
    end
    @(negedge clk);
    rst = 1'b1;
    m0_arvalid = 1; m1_arvalid = 1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, gnt} !== 3'b000) begin
      errors++; $display("FAIL mid_reset_state: got busy/gnt %b want 000", {busy, gnt});
    end
    checks++;
    if ({s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready,
         m0_arready, m1_arready, m0_rvalid, m1_rvalid} !== 9'b0) begin
      errors++;
      $display("FAIL mid_reset_ctl: got %b want 000000000",
               {s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready,
                m0_arready, m1_arready, m0_rvalid, m1_rvalid});
    end
    @(negedge clk); #1;
    checks++;
    if (gnt !== 2'b01) begin errors++; $display("FAIL mid_regrant: got %b want 01", gnt); end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single_write();
    test_contend_read();
    test_back_to_back();
    test_w_before_aw();
    test_rresp_err();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/axi4lite_arb_2m1s.md
AXI4LITE_ARB_2M1S -- requirements
Module: axi4lite_arb_2m1s

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, AXI4-Lite address width on all ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, AXI4-Lite data width; WSTRB is not carried.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port m0_axi_aw{addr,valid}/w{data,valid}/bready/ar{addr,valid}/rready  input  ADDR_WIDTH/1/DATA_WIDTH/1/1/ADDR_WIDTH/1/1  requester 0 AXI4-Lite inputs.
REQ-006 SHALL have port m0_axi_awready/wready/b{resp,valid}/arready/r{data,resp,valid}  output  1/1/2,1/1/DATA_WIDTH,2,1  requester 0 AXI4-Lite outputs.
REQ-007 SHALL have port group m1_axi_*  same directions and widths as REQ-005/006  requester 1.
REQ-008 SHALL have port group s_axi_*  mirrored directions, same widths  the single shared slave.
REQ-009 SHALL have port gnt  output  2  one-hot current owner, 2'b00 when idle.
REQ-010 SHALL have port busy  output  1  high in any state except IDLE.

Function
REQ-011 Requester i requests when m{i}_axi_awvalid OR m{i}_axi_arvalid is high.
REQ-012 Exactly one transaction is in flight at a time; states IDLE, WR, WR_RESP, RD, RD_DATA.
REQ-013 In IDLE with a request: select owner round-robin (requester other than last_owner wins ties; single requester wins outright); register gnt; next state WR if owner's awvalid high, else RD (write before read within a requester).
REQ-014 Arbitration costs exactly one cycle: request seen in cycle N, slave sees valid at cycle N+1 at the earliest.
REQ-015 WR: owner's AW and W channels route combinationally to the slave; aw_done/w_done flags latch each handshake; a completed channel drives slave valid low; both done -> WR_RESP.
REQ-016 WR_RESP: slave B routes to owner; on bvalid&bready -> IDLE, last_owner <= owner, gnt <= 0.
REQ-017 RD: owner's AR routes to slave; arvalid&arready -> RD_DATA.
REQ-018 RD_DATA: slave R routes to owner; rvalid&rready -> IDLE, last_owner <= owner, gnt <= 0.
REQ-019 Non-owner sees awready, wready, arready, bvalid, rvalid all 0 and bresp/rresp/rdata 0; its valids are ignored and never reach the slave.
REQ-020 Slave valids are 0 and slave addr/data 0 in IDLE; s_axi_bready/rready are 0 outside WR_RESP/RD_DATA.
REQ-021 bresp/rresp pass through unmodified (SLVERR/DECERR included).
REQ-022 Owner dropping valid mid-WR/RD (protocol violation) leaves FSM waiting; no timeout.
REQ-023 AW and W completing in the same cycle -> WR_RESP next cycle; W before AW is legal.

Reset
REQ-024 rst high at any edge, including mid-transaction: state IDLE, gnt 2'b00, busy 0, aw_done/w_done 0, last_owner 1 (requester 0 wins first tie), all outputs to requesters and slave 0.
REQ-025 An in-flight slave transaction is abandoned on reset; slave must be reset together with the arbiter.

Structure
REQ-026 Package axi4lite_arb_pkg SHALL hold the state enum and AXI response constants (OKAY 2'b00, EXOKAY 2'b01, SLVERR 2'b10, DECERR 2'b11).
REQ-027 Owner selection SHALL be one sub-module rr_arb2 (inputs req[1:0], last_owner; output one-hot grant, combinational).
REQ-028 Routing muxes and FSM SHALL live in axi4lite_arb_2m1s; no additional storage beyond state, gnt, last_owner, done flags.

Verification
REQ-029 M0 write addr 4'h4 data 32'hDEADBEEF, slave ready 1 -> gnt 2'b01, s_awaddr 4'h4, s_wdata 32'hDEADBEEF, M0 bresp 2'b00, back to IDLE, busy 0.
REQ-030 M0 and M1 both assert arvalid in the same cycle after reset -> M0 served first, M1 next; M1 rdata 32'h12345678 delivered only to M1.
REQ-031 Both requesters issue back-to-back writes continuously for 6 transactions -> gnt sequence 01,10,01,10,01,10.
REQ-032 Slave accepts W 3 cycles before AW -> single AW and single W handshake at slave; WR_RESP entered cycle after AW handshake.
REQ-033 Slave returns rresp 2'b10 to M1 -> M1 sees rresp 2'b10, state IDLE next cycle.
REQ-034 rst asserted in RD_DATA while slave rvalid low -> next cycle state IDLE, gnt 00, all readies/valids 0; next contending request grants M0.
